// File: rtl/bcd_digit_sequencer.sv
// bcd_digit_sequencer: multi-cycle packed-BCD adder that handles one decimal
// digit per clock, least significant digit first.
// Build option: define BCD_DIGIT_CHECK_EN to enable the digit validity
// check that drives err. If it is not defined, err is a constant 0.
//
// state | meaning
// IDLE  | waiting for start; sum/cout/err hold the last result
// ADD   | one digit is added on each clock, idx_q selects the digit
module bcd_digit_sequencer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            done_q, done_d;

  logic [3:0]      a_dig, b_dig, res_dig;
  logic [4:0]      t;
  logic            k;
  logic            last;

  // Add one digit: binary sum, then +6 correction when the sum exceeds 9.
  always_comb begin
    a_dig   = a_q[int'(idx_q)*4 +: 4];
    b_dig   = b_q[int'(idx_q)*4 +: 4];
    t       = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
    k       = t[4] | (t[3] & (t[2] | t[1]));
    res_dig = t[3:0] + (k ? 4'd6 : 4'd0);
    last    = (idx_q == IW'(DIGITS - 1));
  end

  // Next-state logic. Partial digits collect in acc_q, and sum_q is loaded
  // only on the final digit, so the output never shows an incomplete sum.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
          idx_d   = '0;
          carry_d = cin;
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
        end
      end
      ADD: begin
        acc_d[int'(idx_q)*4 +: 4] = res_dig;
        carry_d = k;
        idx_d   = idx_q + 1'b1;
        if (last) begin
          state_d = IDLE;
          idx_d   = '0;
          sum_d   = acc_d;
          cout_d  = k;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset clears everything, including any
  // operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign done = done_q;
  assign busy = (state_q == ADD);

`ifdef BCD_DIGIT_CHECK_EN
  logic flag_q, flag_d;
  logic err_q, err_d;
  logic bad_dig;

  // The sticky flag records any non-BCD operand digit. It is published to err
  // on the final digit, and that final digit counts toward the flag.
  always_comb begin
    bad_dig = (a_dig > 4'd9) | (b_dig > 4'd9);
    flag_d  = flag_q;
    err_d   = err_q;
    if (state_q == IDLE) begin
      if (start) flag_d = 1'b0;
    end else begin
      flag_d = flag_q | bad_dig;
      if (last) err_d = flag_q | bad_dig;
    end
  end

  // Validity flag and err output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Directed testbench for bcd_digit_sequencer with DIGITS=4.
module tb_bcd_digit_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic [15:0] sum;
  logic        cout, busy, done, err;

  int total = 0;
  int bad   = 0;

  bcd_digit_sequencer #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse. On return the start-accept edge has passed and
  // the bench sits on the following falling edge.
  task automatic do_start(input logic [15:0] av, input logic [15:0] bv, input logic c);
    a = av; b = bv; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count falling edges until done is seen, giving up after 20.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL reset_sum: got %h want 0000", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", cout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
  endtask

  task automatic test_basic_add;
    int cyc;
    bit partial;
    partial = 0;
    do_start(16'h1234, 16'h5678, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (sum !== 16'h0000) partial = 1;
      @(negedge clk);
      cyc++;
    end
    total++; if (partial) begin bad++; $display("FAIL basic_no_partial: got sum change while busy want 0000"); end
    total++; if (cyc != 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", cyc); end
    total++; if (sum !== 16'h6912) begin bad++; $display("FAIL basic_sum: got %h want 6912", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL basic_cout: got %b want 0", cout); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    total++; if (sum !== 16'h6912) begin bad++; $display("FAIL basic_sum_hold: got %h want 6912", sum); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    do_start(16'h9999, 16'h0001, 1'b0);
    wait_done(cyc);
    total++; if (cyc != 4) begin bad++; $display("FAIL b2b_lat1: got %0d want 4", cyc); end
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL b2b_sum1: got %h want 0000", sum); end
    total++; if (cout !== 1'b1) begin bad++; $display("FAIL b2b_cout1: got %b want 1", cout); end
    do_start(16'h9999, 16'h9999, 1'b1);
    wait_done(cyc);
    total++; if (cyc != 4) begin bad++; $display("FAIL b2b_lat2: got %0d want 4", cyc); end
    total++; if (sum !== 16'h9999) begin bad++; $display("FAIL b2b_sum2: got %h want 9999", sum); end
    total++; if (cout !== 1'b1) begin bad++; $display("FAIL b2b_cout2: got %b want 1", cout); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int cyc;
    int pulses;
    do_start(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    a = 16'h5555; b = 16'h5555; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 2;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (cyc != 4) begin bad++; $display("FAIL ignore_latency: got %0d want 4", cyc); end
    total++; if (sum !== 16'h3333) begin bad++; $display("FAIL ignore_sum: got %h want 3333", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL ignore_cout: got %b want 0", cout); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL ignore_extra_done: got %0d want 0", pulses); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int pulses;
    do_start(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL rstmid_sum: got %h want 0000", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL rstmid_cout: got %b want 0", cout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", done); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", pulses); end
    do_start(16'h0005, 16'h0005, 1'b0);
    wait_done(cyc);
    total++; if (cyc != 4) begin bad++; $display("FAIL rstmid_latency: got %0d want 4", cyc); end
    total++; if (sum !== 16'h0010) begin bad++; $display("FAIL rstmid_sum2: got %h want 0010", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL rstmid_cout2: got %b want 0", cout); end
    @(negedge clk);
  endtask

  task automatic test_digit_check;
    int cyc;
    logic exp_err;
`ifdef BCD_DIGIT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_start(16'h00A0, 16'h0000, 1'b0);
    wait_done(cyc);
    total++; if (cyc != 4) begin bad++; $display("FAIL chk_latency: got %0d want 4", cyc); end
    total++; if (sum !== 16'h0100) begin bad++; $display("FAIL chk_sum: got %h want 0100", sum); end
    total++; if (err !== exp_err) begin bad++; $display("FAIL chk_err: got %b want %b", err, exp_err); end
    @(negedge clk);
    total++; if (err !== exp_err) begin bad++; $display("FAIL chk_err_hold: got %b want %b", err, exp_err); end
    do_start(16'h0001, 16'h0002, 1'b0);
    wait_done(cyc);
    total++; if (sum !== 16'h0003) begin bad++; $display("FAIL chk_sum2: got %h want 0003", sum); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL chk_err_clear: got %b want 0", err); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_digit_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
